mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one shared RAM port between an instruction fetch path and a data path.
// Data normally wins; a starvation counter forces an instruction grant after STARVE_MAX data grants.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ram_err
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] starve_r;
    logic [CNT_W-1:0] starve_s;
    logic             ram_err_r;
    logic             ram_err_s;
    logic             dreq_s;
    logic             i_force_s;

    assign dreq_s    = dREN | dWEN;
    assign i_force_s = iREN & (starve_r == STARVE_LIM);

    // State, starvation counter and sticky error flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r   <= IDLE;
            starve_r  <= CNT_ZERO;
            ram_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            starve_r  <= starve_s;
            ram_err_r <= ram_err_s;
        end
    end

    // Arbitration, grant sequencing and combinational RAM/requester steering.
    always_comb begin
        state_s   = state_r;
        starve_s  = starve_r;
        ram_err_s = ram_err_r;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = 32'd0;
        ramstore  = 32'd0;
        iload     = 32'd0;
        dload     = 32'd0;
        case (state_r)
            IDLE: begin
                if (dreq_s && !i_force_s) begin
                    state_s = DGNT;
                    if (iREN) begin
                        if (starve_r != STARVE_LIM) begin
                            starve_s = starve_r + CNT_ONE;
                        end else begin
                            starve_s = starve_r;
                        end
                    end else begin
                        starve_s = CNT_ZERO;
                    end
                end else if (iREN) begin
                    state_s  = IGNT;
                    starve_s = CNT_ZERO;
                end else begin
                    state_s  = IDLE;
                    starve_s = CNT_ZERO;
                end
            end
            IGNT: begin
                if (!iREN) begin
                    state_s = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == RAM_ACCESS) begin
                        iload   = ramload;
                        state_s = IDLE;
                    end else if (ramstate == RAM_ERROR) begin
                        ram_err_s = 1'b1;
                        state_s   = IDLE;
                    end else begin
                        state_s = IGNT;
                    end
                end
            end
            DGNT: begin
                if (!dreq_s) begin
                    state_s = IDLE;
                end else begin
                    ramaddr = daddr;
                    // A simultaneous read and write is serviced as the write.
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ramstate == RAM_ACCESS) begin
                        dload   = ramload;
                        state_s = IDLE;
                    end else if (ramstate == RAM_ERROR) begin
                        ram_err_s = 1'b1;
                        state_s   = IDLE;
                    end else begin
                        state_s = DGNT;
                    end
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign iwait   = iREN & ~((state_r == IGNT) & (ramstate == RAM_ACCESS));
    assign dwait   = dreq_s & ~((state_r == DGNT) & (ramstate == RAM_ACCESS));
    assign ram_err = ram_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter with an expected-output queue, plus
// hand sequences for starvation ordering and reset during a grant.
module tb_mem_arbiter;

    localparam logic [31:0] IA = 32'h0000_0100;
    localparam logic [31:0] DA = 32'h0000_0200;
    localparam logic [31:0] DS = 32'h0000_0055;
    localparam logic [31:0] RB = 32'hDEAD_BEEF;
    localparam logic [31:0] RC = 32'h1234_5678;
    localparam logic [1:0]  FREE = 2'd0;
    localparam logic [1:0]  BUSY = 2'd1;
    localparam logic [1:0]  ACC  = 2'd2;
    localparam logic [1:0]  ERR  = 2'd3;
    localparam logic [7:0]  GI = 8'h49;
    localparam logic [7:0]  GD = 8'h44;

    typedef struct packed {
        logic        rren;
        logic        rwen;
        logic [31:0] raddr;
        logic [31:0] rstore;
        logic [31:0] il;
        logic [31:0] dl;
        logic        iw;
        logic        dw;
        logic        err;
    } out_t;

    typedef struct {
        string       name;
        logic        ir;
        logic        dr;
        logic        dwr;
        logic [1:0]  rs;
        logic [31:0] rl;
        out_t        exp;
    } vec_t;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ram_err;

    int   n_vec = 0;
    int   n_bad = 0;
    out_t exp_q[$];
    logic [7:0] grant_q[$];
    vec_t tbl[27];

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .ram_err(ram_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mkv(string n, logic ir, logic dr, logic dwr,
                                 logic [1:0] rs, logic [31:0] rl,
                                 logic ren, logic wen, logic [31:0] ad,
                                 logic [31:0] st, logic [31:0] il,
                                 logic [31:0] dl, logic iw, logic dw,
                                 logic er);
        vec_t v;
        v.name = n; v.ir = ir; v.dr = dr; v.dwr = dwr; v.rs = rs; v.rl = rl;
        v.exp = '{rren: ren, rwen: wen, raddr: ad, rstore: st, il: il,
                  dl: dl, iw: iw, dw: dw, err: er};
        return v;
    endfunction

    function automatic out_t sample();
        out_t o;
        o = '{rren: ramREN, rwen: ramWEN, raddr: ramaddr, rstore: ramstore,
              il: iload, dl: dload, iw: iwait, dw: dwait, err: ram_err};
        return o;
    endfunction

    task automatic check_out(string name);
        out_t e;
        out_t a;
        e = exp_q.pop_front();
        a = sample();
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic check_val(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic observe(int cycles);
        logic [7:0] g;
        logic [7:0] e;
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLK);
            if (ramREN || ramWEN) begin
                g = (ramaddr == IA) ? GI : GD;
                n_vec++;
                if (grant_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL grant_order: got %c expected none", g);
                end else begin
                    e = grant_q.pop_front();
                    if (g !== e) begin
                        n_bad++;
                        $display("FAIL grant_order: got %c expected %c", g, e);
                    end
                end
            end
        end
        check_val("grant_queue_left", grant_q.size(), 32'd0);
        grant_q.delete();
    endtask

    initial begin
        //            name          ir   dr   dw   rs    rl   ren  wen  addr   store  iload  dload  iw   dw   err
        tbl[0]  = mkv("idle0",      1'b0,1'b0,1'b0,FREE, RB,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b0,1'b0,1'b0);
        tbl[1]  = mkv("i_req",      1'b1,1'b0,1'b0,ACC,  RB,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b1,1'b0,1'b0);
        tbl[2]  = mkv("i_done",     1'b1,1'b0,1'b0,ACC,  RB,  1'b1,1'b0,IA,    32'd0, RB,    32'd0, 1'b0,1'b0,1'b0);
        tbl[3]  = mkv("gap",        1'b0,1'b0,1'b0,ACC,  RB,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b0,1'b0,1'b0);
        tbl[4]  = mkv("both_req",   1'b1,1'b0,1'b1,ACC,  RB,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b1,1'b1,1'b0);
        tbl[5]  = mkv("dw_done",    1'b1,1'b0,1'b1,ACC,  RB,  1'b0,1'b1,DA,    DS,    32'd0, RB,    1'b1,1'b0,1'b0);
        tbl[6]  = mkv("i_pending",  1'b1,1'b0,1'b0,ACC,  RB,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b1,1'b0,1'b0);
        tbl[7]  = mkv("i_after_d",  1'b1,1'b0,1'b0,ACC,  RB,  1'b1,1'b0,IA,    32'd0, RB,    32'd0, 1'b0,1'b0,1'b0);
        tbl[8]  = mkv("idle1",      1'b0,1'b0,1'b0,FREE, RB,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b0,1'b0,1'b0);
        tbl[9]  = mkv("dr_req",     1'b0,1'b1,1'b0,BUSY, RC,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b0,1'b1,1'b0);
        tbl[10] = mkv("dr_busy1",   1'b0,1'b1,1'b0,BUSY, RC,  1'b1,1'b0,DA,    32'd0, 32'd0, 32'd0, 1'b0,1'b1,1'b0);
        tbl[11] = mkv("dr_busy2",   1'b0,1'b1,1'b0,BUSY, RC,  1'b1,1'b0,DA,    32'd0, 32'd0, 32'd0, 1'b0,1'b1,1'b0);
        tbl[12] = mkv("dr_busy3",   1'b0,1'b1,1'b0,BUSY, RC,  1'b1,1'b0,DA,    32'd0, 32'd0, 32'd0, 1'b0,1'b1,1'b0);
        tbl[13] = mkv("dr_done",    1'b0,1'b1,1'b0,ACC,  RC,  1'b1,1'b0,DA,    32'd0, 32'd0, RC,    1'b0,1'b0,1'b0);
        tbl[14] = mkv("idle2",      1'b0,1'b0,1'b0,FREE, RC,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b0,1'b0,1'b0);
        tbl[15] = mkv("i_req2",     1'b1,1'b0,1'b0,BUSY, RB,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b1,1'b0,1'b0);
        tbl[16] = mkv("i_busy",     1'b1,1'b0,1'b0,BUSY, RB,  1'b1,1'b0,IA,    32'd0, 32'd0, 32'd0, 1'b1,1'b0,1'b0);
        tbl[17] = mkv("i_abort",    1'b0,1'b0,1'b0,ACC,  RB,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b0,1'b0,1'b0);
        tbl[18] = mkv("post_abort", 1'b0,1'b0,1'b0,ACC,  RB,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b0,1'b0,1'b0);
        tbl[19] = mkv("d_req_err",  1'b0,1'b1,1'b0,ERR,  RB,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b0,1'b1,1'b0);
        tbl[20] = mkv("d_error",    1'b0,1'b1,1'b0,ERR,  RB,  1'b1,1'b0,DA,    32'd0, 32'd0, 32'd0, 1'b0,1'b1,1'b0);
        tbl[21] = mkv("err_idle",   1'b0,1'b1,1'b0,ACC,  RC,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b0,1'b1,1'b1);
        tbl[22] = mkv("d_retry",    1'b0,1'b1,1'b0,ACC,  RC,  1'b1,1'b0,DA,    32'd0, 32'd0, RC,    1'b0,1'b0,1'b1);
        tbl[23] = mkv("idle3",      1'b0,1'b0,1'b0,FREE, RC,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b0,1'b0,1'b1);
        tbl[24] = mkv("rw_req",     1'b0,1'b1,1'b1,ACC,  RB,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b0,1'b1,1'b1);
        tbl[25] = mkv("rw_done",    1'b0,1'b1,1'b1,ACC,  RB,  1'b0,1'b1,DA,    DS,    32'd0, RB,    1'b0,1'b0,1'b1);
        tbl[26] = mkv("idle4",      1'b0,1'b0,1'b0,FREE, RB,  1'b0,1'b0,32'd0, 32'd0, 32'd0, 32'd0, 1'b0,1'b0,1'b1);

        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = IA; daddr = DA; dstore = DS; ramload = RB; ramstate = FREE;

        @(negedge CLK);
        exp_q.push_back(out_t'(0));
        check_out("reset_state");
        @(posedge CLK);
        #1 nRST = 1'b1;

        for (int i = 0; i < 27; i++) begin
            @(posedge CLK);
            #1;
            iREN = tbl[i].ir; dREN = tbl[i].dr; dWEN = tbl[i].dwr;
            ramstate = tbl[i].rs; ramload = tbl[i].rl;
            exp_q.push_back(tbl[i].exp);
            @(negedge CLK);
            check_out(tbl[i].name);
        end

        // Reset pulsed while an instruction grant is waiting on a busy RAM.
        @(posedge CLK);
        #1 iREN = 1'b1; ramstate = BUSY; ramload = RB;
        @(negedge CLK);
        @(negedge CLK);
        check_val("ignt_ren", ramREN, 32'd1);
        check_val("err_sticky", ram_err, 32'd1);
        #2 nRST = 1'b0;
        #1;
        check_val("rst_ren", ramREN, 32'd0);
        check_val("rst_addr", ramaddr, 32'd0);
        check_val("rst_err", ram_err, 32'd0);
        check_val("rst_iwait", iwait, 32'd1);
        check_val("rst_iload", iload, 32'd0);
        @(posedge CLK);
        #1 nRST = 1'b1; iREN = 1'b0; ramstate = FREE;

        // Continuous contention: four data grants, then one forced instruction grant.
        @(posedge CLK);
        #1 iREN = 1'b1; dREN = 1'b1; ramstate = ACC;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) grant_q.push_back(GD);
            grant_q.push_back(GI);
        end
        for (int j = 0; j < 3; j++) grant_q.push_back(GD);
        observe(26);

        // Reset during a data grant must clear the starvation count.
        @(posedge CLK);
        #1 ramstate = BUSY;
        @(negedge CLK);
        @(negedge CLK);
        check_val("dgnt_ren", ramREN, 32'd1);
        check_val("dgnt_addr", ramaddr, DA);
        #2 nRST = 1'b0;
        #1;
        check_val("rst_d_ren", ramREN, 32'd0);
        check_val("rst_d_wen", ramWEN, 32'd0);
        check_val("rst_dload", dload, 32'd0);
        check_val("rst_dwait", dwait, 32'd1);
        @(posedge CLK);
        #1 nRST = 1'b1; ramstate = ACC;
        for (int j = 0; j < 4; j++) grant_q.push_back(GD);
        grant_q.push_back(GI);
        observe(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
